tsp_run_ctrl: RTL and testbench
===============================

# tsp_run_ctrl

Run controller for the TSP solver core. It generates the 64-city coordinate set from a seeded LFSR and writes it into the solver's coordinate registers. It then holds the solver in reset while loading, releases it, and tracks the best (lowest) tour length the solver reports. It ends the run on stagnation, or on a cycle budget when that is compiled in. It sits between the board top level (switches/keys) and the solver, and feeds best-result status to the display logic.

## Interface
- N_CITY, 64, number of cities; address width $clog2(N_CITY)
- PERF_W, 32, width of solver performance (tour length)
- WARMUP, 4, RUN cycles ignored after solver release before sampling performance
- STALL_LIMIT, 1<<20, consecutive RUN sample cycles without improvement that end the run
- MAX_CYCLES, 1<<26, RUN cycle budget (only with TSP_CTRL_TIMEOUT_EN)

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- start  in  1  level; sampled in IDLE/DONE, begins a new run
- abort  in  1  level; returns to IDLE from any state
- seed  in  16  LFSR seed, latched on start
- solver_rst  out  1  reset to solver core
- city_we  out  1  coordinate write strobe
- city_addr  out  6  city index being written
- city_x  out  8  x coordinate
- city_y  out  8  y coordinate
- performance  in  PERF_W  current tour length from solver
- best_perf  out  PERF_W  lowest sampled tour length this run
- best_upd  out  1  one-cycle pulse when best_perf improves
- run_cycles  out  32  RUN cycles elapsed, saturating
- state  out  3  current state encoding
- done  out  1  high in DONE

## Operation
- States: IDLE(0), LOAD(1), SETTLE(2), RUN(3), DONE(4).
- IDLE: solver_rst=1. If start=1, latch seed and go to LOAD. A seed of 0 is replaced by 16'hACE1.
- LOAD: one city per cycle. city_we=1, city_addr=k, city_x=lfsr[15:8], city_y=lfsr[7:0], for k=0..N_CITY-1. The LFSR advances one step per city.
  - LFSR is Fibonacci, polynomial x^16+x^14+x^13+x^11+1, shifting left with the feedback bit entering at bit 0.
  - After city N_CITY-1, go to SETTLE. solver_rst stays 1 throughout LOAD.
- SETTLE: one cycle. solver_rst=1, city_we=0. Clear best_perf to all ones, run_cycles to 0, and the stall counter to 0. Next state is RUN.
- RUN: solver_rst=0. run_cycles increments each cycle and saturates at 2^32-1.
  - For the first WARMUP cycles, performance is not sampled.
  - Afterwards, each cycle: if performance < best_perf, load best_perf, pulse best_upd, and clear the stall counter. Otherwise, increment the stall counter.
  - When the stall counter reaches STALL_LIMIT, go to DONE.
- DONE: solver_rst=0, so the solver keeps its final path for display. done=1, best_perf is held. start=1 begins a new run (to LOAD, new seed latched).
- abort=1 has priority over every other transition. The next state is IDLE, and solver_rst=1 from the following cycle. best_perf and run_cycles are held.
- Equal performance is not an improvement. A performance value of all ones never updates best_perf.

## Timing
- All outputs are registered.
- Reset values: state=IDLE, solver_rst=1, city_we=0, city_addr=0, city_x=0, city_y=0, best_perf=all ones, best_upd=0, run_cycles=0, done=0.
- start sampled at edge t puts LOAD in effect at t+1. The first write (addr 0) is visible at t+1, and the last (addr 63) at t+64.
- SETTLE is at t+65. RUN begins at t+66, with solver_rst low from t+66.
- best_upd is asserted in the cycle after the sampled improvement, coincident with the new best_perf value.
- rst mid-run: immediate return to reset values on the next edge. The loaded coordinates are not rewritten.
- If start and abort are both high, abort wins and the controller stays in IDLE.

## Configuration
- TSP_CTRL_TIMEOUT_EN defined: RUN also ends in DONE when run_cycles reaches MAX_CYCLES, even if still improving. Stall and timeout in the same cycle both yield DONE.
- TSP_CTRL_TIMEOUT_EN undefined: no budget. Only stagnation or abort ends RUN, and the MAX_CYCLES parameter is unused.

## Structure
- Shared package tsp_pkg holds:
  - the state enum type tsp_ctrl_state_t
  - N_CITY, COORD_W=8, PERF_W
  - LFSR_TAPS=16'hB400
  - LFSR_DEFAULT_SEED=16'hACE1
- One sub-module, tsp_lfsr16, with ports clk, load, seed, step, and q[15:0]; it performs the seed-zero substitution internally.
- The stall counter, warmup counter and run counter live in tsp_run_ctrl.

## Test plan
- Reset, then start with seed=16'h0001 → 64 writes on consecutive cycles. Addr 0 gives x=8'h00, y=8'h01; each subsequent value is one LFSR step later. solver_rst falls exactly 66 cycles after start.
- Seed=0 → first write gives x=8'hAC, y=8'hE1.
- In RUN, drive performance=1000, 900, 900, 950, 800 after warmup → best_upd pulses three times, and best_perf ends at 800.
- Hold performance constant with STALL_LIMIT=16 → done asserts after 16 non-improving samples plus 1 cycle. best_perf is held, and a new start restarts LOAD.
- Assert abort mid-LOAD at city 20 → IDLE next cycle, city_we=0, solver_rst=1. A subsequent start reloads from addr 0.
- With TSP_CTRL_TIMEOUT_EN, MAX_CYCLES=100, and strictly decreasing performance → DONE at run_cycles=100. Without the macro, the run continues.

Source files
------------

// File: rtl/tsp_pkg.sv
// Shared types and constants for the TSP solver run controller.
package tsp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_RUN    = 3'd3,
    ST_DONE   = 3'd4
  } tsp_ctrl_state_t;

  localparam int N_CITY  = 64;
  localparam int ADDR_W  = $clog2(N_CITY);
  localparam int COORD_W = 8;
  localparam int PERF_W  = 32;

  localparam logic [15:0] LFSR_TAPS         = 16'hB400;
  localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

  // x^16+x^14+x^13+x^11+1, shifted left with feedback into bit 0
  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {v[14:0], ^(v & LFSR_TAPS)};
  endfunction

  // An all-zero seed would lock the LFSR, so it is replaced.
  function automatic logic [15:0] lfsr_seed_fix(input logic [15:0] s);
    return (s == 16'h0000) ? LFSR_DEFAULT_SEED : s;
  endfunction

endpackage

// File: rtl/tsp_lfsr16.sv
// 16-bit Fibonacci LFSR used to generate city coordinates; zero seeds are substituted.
module tsp_lfsr16
  import tsp_pkg::*;
(
  input  logic        clk,
  input  logic        load,
  input  logic [15:0] seed,
  input  logic        step,
  output logic [15:0] q
);

  always_ff @(posedge clk) begin
    if (load) begin
      q <= lfsr_seed_fix(seed);
    end else if (step) begin
      q <= lfsr_next(q);
    end
  end

endmodule

// File: rtl/tsp_run_ctrl.sv
// Run controller: loads LFSR city coordinates, releases the solver, tracks best tour length.
// Optional run-cycle budget enabled by defining TSP_CTRL_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | solver held in reset, waiting for start
// LOAD   | writing one city coordinate per cycle
// SETTLE | one cycle, clears best/run/stall tracking
// RUN    | solver released, sampling performance after warmup
// DONE   | run ended, best held, solver keeps its final path
module tsp_run_ctrl
  import tsp_pkg::*;
#(
  parameter int WARMUP      = 4,
  parameter int STALL_LIMIT = 1 << 20,
  parameter int MAX_CYCLES  = 1 << 26
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [15:0]        seed,
  output logic               solver_rst,
  output logic               city_we,
  output logic [ADDR_W-1:0]  city_addr,
  output logic [COORD_W-1:0] city_x,
  output logic [COORD_W-1:0] city_y,
  input  logic [PERF_W-1:0]  performance,
  output logic [PERF_W-1:0]  best_perf,
  output logic               best_upd,
  output logic [31:0]        run_cycles,
  output logic [2:0]         state,
  output logic               done
);

  localparam logic [2:0] S_IDLE   = ST_IDLE;
  localparam logic [2:0] S_LOAD   = ST_LOAD;
  localparam logic [2:0] S_SETTLE = ST_SETTLE;
  localparam logic [2:0] S_RUN    = ST_RUN;
  localparam logic [2:0] S_DONE   = ST_DONE;

  localparam int WARM_W  = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
  localparam int STALL_W = $clog2(STALL_LIMIT + 1);

  logic [2:0]         st_nx;
  logic [WARM_W-1:0]  warm_left;
  logic [STALL_W-1:0] stall_left;
  logic [15:0]        lfsr_q;
  logic               lfsr_load;
  logic               lfsr_step;
  logic               last_city;
  logic               sample;
  logic               improve;
  logic               stall_hit;
  logic               timeout_hit;

  tsp_lfsr16 u_lfsr (
    .clk  (clk),
    .load (lfsr_load),
    .seed (seed),
    .step (lfsr_step),
    .q    (lfsr_q)
  );

  assign lfsr_load = (state == S_IDLE || state == S_DONE) && start && !abort;
  assign lfsr_step = (state == S_LOAD);
  assign last_city = (city_addr == ADDR_W'(N_CITY - 1));
  assign sample    = (state == S_RUN) && (warm_left == '0);
  assign improve   = sample && (performance < best_perf);
  // Stall tracking is a down-counter: reloaded on improvement, terminal count at 1.
  assign stall_hit = sample && !improve && (stall_left == STALL_W'(1));

`ifdef TSP_CTRL_TIMEOUT_EN
  assign timeout_hit = (state == S_RUN) && (run_cycles == 32'(MAX_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    st_nx = state;
    case (state)
      S_IDLE, S_DONE: if (start) st_nx = S_LOAD;
      S_LOAD:         if (last_city) st_nx = S_SETTLE;
      S_SETTLE:       st_nx = S_RUN;
      S_RUN:          if (stall_hit || timeout_hit) st_nx = S_DONE;
      default:        st_nx = S_IDLE;
    endcase
    if (abort) st_nx = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      solver_rst <= 1'b1;
      city_we    <= 1'b0;
      city_addr  <= '0;
      city_x     <= '0;
      city_y     <= '0;
      best_perf  <= '1;
      best_upd   <= 1'b0;
      run_cycles <= '0;
      done       <= 1'b0;
      warm_left  <= '0;
      stall_left <= '0;
    end else begin
      state      <= st_nx;
      solver_rst <= !(st_nx == S_RUN || st_nx == S_DONE);
      done       <= (st_nx == S_DONE);
      city_we    <= (st_nx == S_LOAD);
      best_upd   <= 1'b0;

      // Coordinate registers track the LFSR so the first city is visible with the LOAD state.
      if (lfsr_load) begin
        city_addr        <= '0;
        {city_x, city_y} <= lfsr_seed_fix(seed);
      end else if (state == S_LOAD && st_nx == S_LOAD) begin
        city_addr        <= city_addr + 1'b1;
        {city_x, city_y} <= lfsr_next(lfsr_q);
      end

      if (state == S_SETTLE && !abort) begin
        best_perf  <= '1;
        run_cycles <= '0;
        warm_left  <= WARM_W'(WARMUP);
        stall_left <= STALL_W'(STALL_LIMIT);
      end

      if (state == S_RUN && !abort) begin
        if (run_cycles != '1) run_cycles <= run_cycles + 32'd1;
        if (warm_left != '0) warm_left <= warm_left - 1'b1;
        if (improve) begin
          best_perf  <= performance;
          best_upd   <= 1'b1;
          stall_left <= STALL_W'(STALL_LIMIT);
        end else if (sample) begin
          stall_left <= stall_left - 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_tsp_run_ctrl.sv
// Self-checking bench for tsp_run_ctrl: behavioural model plus directed and random stimulus.
module tb_tsp_run_ctrl;

  localparam int WARMUP      = 4;
  localparam int STALL_LIMIT = 16;
  localparam int MAX_CYCLES  = 100;

  logic        clk = 1'b0;
  logic        rst, start, abort;
  logic [15:0] seed;
  logic [31:0] performance;
  logic        solver_rst, city_we, best_upd, done;
  logic [5:0]  city_addr;
  logic [7:0]  city_x, city_y;
  logic [31:0] best_perf, run_cycles;
  logic [2:0]  state;

  always #5 clk = ~clk;

  tsp_run_ctrl #(
    .WARMUP      (WARMUP),
    .STALL_LIMIT (STALL_LIMIT),
    .MAX_CYCLES  (MAX_CYCLES)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .seed        (seed),
    .solver_rst  (solver_rst),
    .city_we     (city_we),
    .city_addr   (city_addr),
    .city_x      (city_x),
    .city_y      (city_y),
    .performance (performance),
    .best_perf   (best_perf),
    .best_upd    (best_upd),
    .run_cycles  (run_cycles),
    .state       (state),
    .done        (done)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Model: phase uses the published state numbers; everything else is counted directly.
  int          m_phase;
  int          m_addr;
  bit          m_srst, m_we, m_upd, m_done, m_coord_zero;
  logic [15:0] m_city [64];
  logic [31:0] m_best;
  longint      m_run;
  int          m_stall;

  function automatic logic [15:0] ref_step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_step();
    logic [15:0] v;
    bit sampled;
    if (rst) begin
      m_phase = 0; m_srst = 1; m_we = 0; m_addr = 0; m_best = '1;
      m_upd = 0; m_run = 0; m_done = 0; m_stall = 0; m_coord_zero = 1;
      return;
    end
    m_upd = 0;
    if (abort) begin
      m_phase = 0; m_srst = 1; m_we = 0; m_done = 0;
      return;
    end
    case (m_phase)
      0, 4: if (start) begin
        v = (seed == 16'h0) ? 16'hACE1 : seed;
        for (int i = 0; i < 64; i++) begin
          m_city[i] = v;
          v = ref_step(v);
        end
        m_phase = 1; m_addr = 0; m_we = 1; m_srst = 1; m_done = 0; m_coord_zero = 0;
      end
      1: if (m_addr == 63) begin
        m_phase = 2; m_we = 0;
      end else begin
        m_addr++;
      end
      2: begin
        m_best = '1; m_run = 0; m_stall = 0; m_phase = 3; m_srst = 0;
      end
      3: begin
        sampled = (m_run >= WARMUP);
        if (m_run < 64'hFFFF_FFFF) m_run++;
        if (sampled) begin
          if (performance < m_best) begin
            m_best = performance; m_upd = 1; m_stall = 0;
          end else begin
            m_stall++;
          end
        end
        if (sampled && m_stall == STALL_LIMIT) begin
          m_phase = 4; m_done = 1;
        end
`ifdef TSP_CTRL_TIMEOUT_EN
        if (m_run == MAX_CYCLES) begin
          m_phase = 4; m_done = 1;
        end
`endif
      end
      default: m_phase = 0;
    endcase
  endtask

  task automatic compare_all();
    check("state", state, m_phase);
    check("solver_rst", solver_rst, m_srst);
    check("city_we", city_we, m_we);
    check("done", done, m_done);
    check("best_perf", best_perf, m_best);
    check("best_upd", best_upd, m_upd);
    check("run_cycles", run_cycles, m_run);
    if (m_coord_zero) begin
      check("city_addr", city_addr, 0);
      check("city_x", city_x, 0);
      check("city_y", city_y, 0);
    end else if (m_we) begin
      check("city_addr", city_addr, m_addr);
      check("city_x", city_x, m_city[m_addr][15:8]);
      check("city_y", city_y, m_city[m_addr][7:0]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic wait_run(input string name);
    int n = 0;
    while (solver_rst && n < 200) begin tick(); n++; end
    check(name, solver_rst, 0);
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!done && n < 500) begin tick(); n++; end
    check(name, done, 1);
  endtask

  initial begin
    int s_edge, upd_cnt, n;
    logic [31:0] pseq [5];
    pseq[0] = 1000; pseq[1] = 900; pseq[2] = 900; pseq[3] = 950; pseq[4] = 800;

    rst = 1; start = 0; abort = 0; seed = 16'h0; performance = '1;
    tick(); tick();
    check("rst_state", state, 0);
    check("rst_solver_rst", solver_rst, 1);
    check("rst_best", best_perf, 32'hFFFF_FFFF);
    check("rst_city_x", city_x, 0);
    rst = 0;
    tick();

    // Seed 1: literal coordinates and release timing
    seed = 16'h0001; start = 1;
    tick(); s_edge = cyc; start = 0;
    check("seed1_addr0_x", city_x, 8'h00);
    check("seed1_addr0_y", city_y, 8'h01);
    check("seed1_state_load", state, 1);
    tick();
    check("seed1_addr1_y", city_y, 8'h02);
    wait_run("wait_release1");
    check("release_cycle", cyc - s_edge + 1, 66);

    // Constant performance: one improvement then STALL_LIMIT stagnant samples
    performance = 5000;
    wait_done("wait_stall_done");
    check("stall_done_cycle", cyc - s_edge + 1, 87);
    check("stall_run_cycles", run_cycles, 21);
    performance = 3;
    tick(); tick(); tick();
    check("done_best_held", best_perf, 5000);

    // Restart from DONE with seed 0
    seed = 16'h0000; start = 1;
    tick(); start = 0;
    check("seed0_state_load", state, 1);
    check("seed0_x", city_x, 8'hAC);
    check("seed0_y", city_y, 8'hE1);
    wait_run("wait_release2");

    // Warmup values must be ignored, then 1000,900,900,950,800
    performance = 10;
    for (int i = 0; i < WARMUP; i++) tick();
    check("warmup_best_untouched", best_perf, 32'hFFFF_FFFF);
    upd_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      performance = pseq[i]; tick();
      upd_cnt += int'(best_upd);
    end
    performance = 32'hFFFF_FFFF;
    tick(); upd_cnt += int'(best_upd);
    performance = 800;
    tick(); upd_cnt += int'(best_upd);
    check("seq_upd_count", upd_cnt, 3);
    check("seq_best", best_perf, 800);
    wait_done("wait_seq_done");

    // Abort in the middle of LOAD, with start also asserted
    seed = 16'h1234; start = 1;
    tick(); start = 0;
    n = 0;
    while (city_addr != 6'd20 && n < 100) begin tick(); n++; end
    check("reach_city20", city_addr, 20);
    abort = 1; start = 1;
    tick();
    check("abort_state", state, 0);
    check("abort_we", city_we, 0);
    check("abort_srst", solver_rst, 1);
    tick();
    check("abort_wins_state", state, 0);
    abort = 0;
    tick(); start = 0;
    check("reload_addr", city_addr, 0);
    check("reload_x", city_x, 8'h12);
    check("reload_y", city_y, 8'h34);
    wait_run("wait_release3");

    // Strictly improving run: only the optional budget can end it
    for (int i = 0; i < 150; i++) begin
      performance = 32'(100000 - i); tick();
    end
`ifdef TSP_CTRL_TIMEOUT_EN
    check("budget_done", done, 1);
    check("budget_run_cycles", run_cycles, MAX_CYCLES);
`else
    check("no_budget_running", state, 3);
    check("no_budget_run_cycles", run_cycles, 150);
`endif
    abort = 1; tick(); abort = 0;
    check("abort_run_held", run_cycles, m_run);
    tick();

    // Random phase
    performance = 32'd50000;
    for (int i = 0; i < 4000; i++) begin
      rst   = ($urandom_range(0, 1499) == 0);
      abort = ($urandom_range(0, 249) == 0);
      start = ($urandom_range(0, 14) == 0);
      seed  = 16'($urandom_range(0, 3) == 0 ? 0 : $urandom);
      case ($urandom_range(0, 9))
        0:       performance = '1;
        1, 2:    performance = $urandom_range(0, 100000);
        3:       if (performance != 0) performance = performance - 1;
        default: ;
      endcase
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
